// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: responder FSM encoding, phase geometry and default ID.
// Also imported by the SCCB initiator.
package sccb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DEVID  = 3'd1,
        ST_ADDR   = 3'd2,
        ST_WDATA  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_IGNORE = 3'd5
    } sccb_state_e;

    localparam int unsigned SCCB_BITS_PER_PHASE = 9;
    localparam logic [3:0]  SCCB_LAST_BIT       = 4'(SCCB_BITS_PER_PHASE - 1);
    localparam logic [6:0]  SCCB_DEFAULT_ID     = 7'h21;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronises sio_c/sio_d into the bus clock domain and flags clock edges
// plus start/stop conditions.
module sccb_line_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_sync,
    output logic o_sda_sync,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_prev;
    logic       r_sda_prev;
    logic       w_scl_steady_hi;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
            r_scl_prev <= r_scl_sync[1];
            r_sda_prev <= r_sda_sync[1];
        end
    end

    assign o_scl_sync = r_scl_sync[1];
    assign o_sda_sync = r_sda_sync[1];
    assign o_scl_rise = r_scl_sync[1] & ~r_scl_prev;
    assign o_scl_fall = ~r_scl_sync[1] & r_scl_prev;

    // scl must be high on both sides of the sda edge; a simultaneous scl change is a data change
    assign w_scl_steady_hi = r_scl_sync[1] & r_scl_prev;
    assign o_start = w_scl_steady_hi & ~r_sda_sync[1] & r_sda_prev;
    assign o_stop  = w_scl_steady_hi & r_sda_sync[1] & ~r_sda_prev;

endmodule

// File: rtl/sccb_target.sv
// SCCB responder serving a 256x8 register file; models the camera end of the
// link so the on-chip SCCB initiator can be exercised without a sensor.
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEVICE_ID = SCCB_DEFAULT_ID,
    parameter logic       DRIVE_ACK = 1'b1
) (
    input  logic       sccb_clk,
    input  logic       sccb_reset_n,
    input  logic       sio_c,
    inout  wire        sio_d,
    input  logic       pwdn,
    output logic       reg_wr,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic [7:0] debug_out
);

    sccb_state_e r_state;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_addr;
    logic [7:0]  r_rdata;
    logic        r_oe;
    logic        r_sdo;
    logic [7:0]  r_mem [256];

    logic        w_scl_sync;
    logic        w_sda_sync;
    logic        w_scl_rise;
    logic        w_scl_fall;
    logic        w_start;
    logic        w_stop;
    logic        w_id_match;
    logic        w_ack_phase;
    logic [7:0]  w_mem_rd;

    sccb_line_sync u_line_sync (
        .i_clk      (sccb_clk),
        .i_rst_n    (sccb_reset_n),
        .i_scl      (sio_c),
        .i_sda      (sio_d),
        .o_scl_sync (w_scl_sync),
        .o_sda_sync (w_sda_sync),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_id_match  = (r_shift[7:1] == DEVICE_ID);
    assign w_ack_phase = DRIVE_ACK && ((r_state == ST_ADDR) || (r_state == ST_WDATA) ||
                                       ((r_state == ST_DEVID) && w_id_match));
    assign w_mem_rd    = r_mem[r_addr];

    always_ff @(posedge sccb_clk) begin
        if (!sccb_reset_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_addr    <= '0;
            r_rdata   <= '0;
            r_oe      <= 1'b0;
            r_sdo     <= 1'b1;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            for (int unsigned i = 0; i < 256; i++) begin
                r_mem[8'(i)] <= '0;
            end
        end else begin
            reg_wr <= 1'b0;
            if (pwdn || w_stop) begin
                r_state   <= ST_IDLE;
                r_oe      <= 1'b0;
                r_bit_cnt <= '0;
            end else if (w_start) begin
                r_state   <= ST_DEVID;
                r_oe      <= 1'b0;
                r_bit_cnt <= '0;
            end else if (r_state != ST_IDLE && r_state != ST_IGNORE) begin
                if (w_scl_rise) begin
                    if (r_bit_cnt != SCCB_LAST_BIT) begin
                        r_shift   <= {r_shift[6:0], w_sda_sync};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end else begin
                        // 9th-bit rise: the phase byte is complete and acted on here
                        r_bit_cnt <= '0;
                        case (r_state)
                            ST_DEVID: begin
                                if (!w_id_match)    r_state <= ST_IGNORE;
                                else if (r_shift[0]) r_state <= ST_RDATA;
                                else                r_state <= ST_ADDR;
                            end
                            ST_ADDR: begin
                                r_addr  <= r_shift;
                                r_state <= ST_WDATA;
                            end
                            ST_WDATA: begin
                                r_mem[r_addr] <= r_shift;
                                reg_wr        <= 1'b1;
                                reg_addr      <= r_addr;
                                reg_wdata     <= r_shift;
                                r_addr        <= r_addr + 8'd1;
                            end
                            ST_RDATA: begin
                                r_addr <= r_addr + 8'd1;
                                if (w_sda_sync) r_state <= ST_IGNORE;
                            end
                            default: r_state <= ST_IGNORE;
                        endcase
                    end
                end else if (w_scl_fall) begin
                    if (r_state == ST_RDATA) begin
                        // Count 0 loads the byte and presents its MSB; count 8 hands the line back for NA
                        if (r_bit_cnt == 4'd0) begin
                            r_oe    <= 1'b1;
                            r_sdo   <= w_mem_rd[7];
                            r_rdata <= {w_mem_rd[6:0], 1'b0};
                        end else if (r_bit_cnt != SCCB_LAST_BIT) begin
                            r_oe    <= 1'b1;
                            r_sdo   <= r_rdata[7];
                            r_rdata <= {r_rdata[6:0], 1'b0};
                        end else begin
                            r_oe <= 1'b0;
                        end
                    end else begin
                        r_oe  <= (r_bit_cnt == SCCB_LAST_BIT) && w_ack_phase;
                        r_sdo <= 1'b0;
                    end
                end
            end
        end
    end

    assign sio_d     = r_oe ? r_sdo : 1'bz;
    assign debug_out = {r_oe, w_sda_sync, w_scl_sync, (r_state != ST_IDLE), 1'b0, 3'(r_state)};

endmodule

// File: tb/tb_sccb_target.sv
// Directed plus randomized bench for sccb_target against a transaction-level
// register-file model.
module tb_sccb_target;

    localparam logic [6:0]  TB_ID = 7'h21;
    localparam int unsigned Q     = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl;
    logic        tb_sda;
    logic        pwdn;
    wire         sio_d;
    logic        reg_wr;
    logic [7:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  debug_out;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0]  ref_mem [256];
    logic [7:0]  ref_addr;
    logic [15:0] exp_wr [$];
    logic [15:0] obs_wr [$];
    int unsigned obs_rd = 0;
    int unsigned oe_cycles = 0;
    logic [7:0]  wq [$];

    always #5 clk = ~clk;

    assign sio_d = tb_sda ? 1'bz : 1'b0;
    pullup (sio_d);

    sccb_target #(.DEVICE_ID(TB_ID), .DRIVE_ACK(1'b1)) dut (
        .sccb_clk     (clk),
        .sccb_reset_n (rst_n),
        .sio_c        (scl),
        .sio_d        (sio_d),
        .pwdn         (pwdn),
        .reg_wr       (reg_wr),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .debug_out    (debug_out)
    );

    always @(negedge clk) begin
        if (reg_wr === 1'b1) obs_wr.push_back({reg_addr, reg_wdata});
        if (debug_out[7] === 1'b1) oe_cycles++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        if (!scl) begin
            tb_sda = 1'b1; wait_clk(Q);
            scl = 1'b1;    wait_clk(Q);
        end
        tb_sda = 1'b0; wait_clk(Q);
        scl = 1'b0;    wait_clk(Q);
    endtask

    task automatic bus_stop();
        tb_sda = 1'b0; wait_clk(Q);
        scl = 1'b1;    wait_clk(Q);
        tb_sda = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic clock_bit(input logic b, output logic sda_seen, output logic oe_seen);
        tb_sda = b; wait_clk(Q);
        scl = 1'b1; wait_clk(Q);
        sda_seen = sio_d;
        oe_seen  = debug_out[7];
        wait_clk(Q);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string tag);
        logic s, o;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s, o);
        clock_bit(1'b1, s, o);
        chk({tag, "_ack_oe"}, 32'(o), 32'(exp_ack));
        if (exp_ack) chk({tag, "_ack_sda"}, 32'(s), 32'd0);
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic na, input string tag);
        logic [7:0]  got;
        logic        s, o;
        int unsigned drv = 0;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s, o);
            got[i] = s;
            if (o) drv++;
        end
        chk({tag, "_rdata"}, 32'(got), 32'(exp));
        chk({tag, "_rdrive"}, drv, 32'd8);
        clock_bit(na, s, o);
        chk({tag, "_na_released"}, 32'(o), 32'd0);
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_addr = 8'h00;
        exp_wr.delete();
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_wr_count"}, 32'(obs_wr.size()) - obs_rd, 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size(); i++) begin
            if (obs_rd + i < obs_wr.size())
                chk({tag, "_wr"}, 32'(obs_wr[obs_rd + i]), 32'(exp_wr[i]));
            else
                chk({tag, "_wr_missing"}, 32'hDEAD_BEEF, 32'(exp_wr[i]));
        end
        obs_rd = obs_wr.size();
        exp_wr.delete();
    endtask

    // Start, ID, sub-address, bytes from wq, stop; model updated only when the ID is ours.
    task automatic do_write(input logic [6:0] id, input logic [7:0] sub, input string tag);
        logic ok;
        ok = (id == TB_ID);
        bus_start();
        send_byte({id, 1'b0}, ok, {tag, "_id"});
        send_byte(sub, ok, {tag, "_sub"});
        if (ok) ref_addr = sub;
        foreach (wq[k]) begin
            send_byte(wq[k], ok, {tag, "_data"});
            if (ok) begin
                ref_mem[ref_addr] = wq[k];
                exp_wr.push_back({ref_addr, wq[k]});
                ref_addr = ref_addr + 8'd1;
            end
        end
        bus_stop();
        check_writes(tag);
    endtask

    task automatic do_read(input logic [7:0] sub, input int unsigned n, input string tag);
        wq.delete();
        do_write(TB_ID, sub, {tag, "_set"});
        bus_start();
        send_byte({TB_ID, 1'b1}, 1'b1, {tag, "_rid"});
        for (int unsigned k = 0; k < n; k++) begin
            read_byte(ref_mem[ref_addr], (k == n - 1), tag);
            ref_addr = ref_addr + 8'd1;
        end
        chk({tag, "_after_na"}, 32'(debug_out[2:0]), 32'd5);
        bus_stop();
        chk({tag, "_idle"}, 32'(debug_out[4:0]), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        wait_clk(3);
        chk({tag, "_debug"}, 32'(debug_out), 32'h60);
        chk({tag, "_reg_wr"}, 32'(reg_wr), 32'd0);
        chk({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
        chk({tag, "_reg_wdata"}, 32'(reg_wdata), 32'd0);
        chk({tag, "_sio_d"}, 32'(sio_d), 32'd1);
        rst_n = 1'b1;
        mdl_reset();
        wait_clk(4);
    endtask

    initial begin
        logic [7:0]  b;
        logic        s, o;
        int unsigned oe_before;
        logic [6:0]  id;

        scl = 1'b1; tb_sda = 1'b1; pwdn = 1'b0; rst_n = 1'b0;
        wait_clk(2);
        do_reset("reset");

        // Three-phase write
        wq = '{8'h80};
        do_write(TB_ID, 8'h12, "wr3");

        // Two-phase write then two-phase read of the same location
        do_read(8'h12, 1, "rd_0x12");

        // Sequential write across the address wrap, then read back across it
        wq = '{8'h11, 8'h22};
        do_write(TB_ID, 8'hFF, "seq_wrap");
        do_read(8'hFF, 2, "rd_wrap");

        // Foreign ID: never acknowledged, never written, parked in IGNORE
        oe_before = oe_cycles;
        wq.delete();
        bus_start();
        send_byte(8'h60, 1'b0, "bad_id");
        chk("bad_id_state", 32'(debug_out[2:0]), 32'd5);
        send_byte(8'h05, 1'b0, "bad_sub");
        send_byte(8'hAA, 1'b0, "bad_data");
        chk("bad_state_hold", 32'(debug_out[2:0]), 32'd5);
        bus_stop();
        chk("bad_idle", 32'(debug_out[2:0]), 32'd0);
        chk("bad_never_driven", oe_cycles - oe_before, 32'd0);
        check_writes("bad");

        // Reset in the middle of a data byte
        bus_start();
        send_byte({TB_ID, 1'b0}, 1'b1, "rstmid_id");
        send_byte(8'h34, 1'b1, "rstmid_sub");
        b = 8'h5A;
        for (int i = 7; i >= 4; i--) clock_bit(b[i], s, o);
        do_reset("rstmid");
        bus_stop();
        check_writes("rstmid_none");
        wq = '{8'h5A};
        do_write(TB_ID, 8'h34, "after_rst");
        do_read(8'h12, 1, "rd_cleared");

        // Repeated start inside ADDR returns to DEVID with a fresh bit count
        bus_start();
        send_byte({TB_ID, 1'b0}, 1'b1, "rs_id");
        b = 8'h77;
        for (int i = 7; i >= 5; i--) clock_bit(b[i], s, o);
        bus_start();
        chk("rs_state", 32'(debug_out[2:0]), 32'd1);
        wq = '{8'(($urandom & 32'hFF))};
        do_write(TB_ID, 8'h77, "rs_write");

        // Randomized write traffic, some to foreign IDs
        for (int t = 0; t < 6; t++) begin
            wq.delete();
            for (int unsigned k = 0; k < $urandom_range(1, 3); k++) wq.push_back(8'($urandom_range(0, 255)));
            id = TB_ID;
            if ($urandom_range(0, 3) == 0) begin
                id = 7'($urandom_range(0, 127));
                if (id == TB_ID) id = id ^ 7'h40;
            end
            do_write(id, 8'($urandom_range(0, 255)), "rand_wr");
        end
        for (int t = 0; t < 3; t++)
            do_read(8'($urandom_range(0, 255)), $urandom_range(1, 3), "rand_rd");
        do_read(8'h34, 2, "rd_0x34");

        // Power-down while the responder is serialising read data
        wq.delete();
        do_write(TB_ID, 8'h34, "pw_set");
        bus_start();
        send_byte({TB_ID, 1'b1}, 1'b1, "pw_rid");
        for (int i = 0; i < 3; i++) clock_bit(1'b1, s, o);
        chk("pw_driving", 32'(debug_out[7]), 32'd1);
        pwdn = 1'b1;
        wait_clk(1);
        chk("pw_oe", 32'(debug_out[7]), 32'd0);
        chk("pw_state", 32'(debug_out[2:0]), 32'd0);
        bus_stop();
        pwdn = 1'b0;
        wait_clk(4);
        do_read(8'h34, 1, "pw_kept");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sccb_target.md
Name: sccb_target

Overview:
- SCCB responder (camera-side end of the 3-wire SCCB link), synthesizable, clocked by the system bus clock.
- Oversamples sio_c/sio_d, decodes start/stop, device ID, sub-address and data phases.
- Serves an internal 256x8 register file. Used as the on-FPGA camera register model for bring-up and self-test of the SCCB initiator.

Parameters:
- DEVICE_ID, 7'h21, 7-bit SCCB slave ID (write byte 8'h42, read byte 8'h43).
- DRIVE_ACK, 1, 1 = drive sio_d low during the 9th (don't-care) bit of received phases; 0 = leave released.

Ports:
- sccb_clk  input  1  bus clock; must be ≥8x SCL rate.
- sccb_reset_n  input  1  reset, synchronous, active-low.
- sio_c  input  1  SCCB clock from initiator.
- sio_d  inout  1  SCCB data; driven only as 0/1 when oe set, else 1'bz.
- pwdn  input  1  power-down; 1 forces IDLE and releases sio_d.
- reg_wr  output  1  one-cycle strobe per completed data-byte write.
- reg_addr  output  8  sub-address of that write.
- reg_wdata  output  8  data of that write.
- debug_out  output  8  {sio_d_oe, sda_sync, scl_sync, busy, 1'b0, state[2:0]}.

Behaviour:
- Reset, sampled on sccb_clk rise while sccb_reset_n=0: state=IDLE; oe=0 (sio_d=z); reg_wr=0; reg_addr=0; reg_wdata=0; bit counter=0; all 256 registers=8'h00; synchronizers=1. Reset mid-transfer aborts the transfer with no write strobe.
- Input sync: 2-FF synchronizers on sio_c and sio_d, plus one history FF for edge detect. Events are recognised 3 sccb_clk cycles after the pin edge.
- Start: sda falls while scl=1. Valid in any state, including a repeated start. Effect: bit counter=0, state=DEVID, oe=0.
- Stop: sda rises while scl=1. Effect: state=IDLE, oe=0. The sub-address is retained.
- Sampling: on detected scl rise, shift sda in. Bits 0-7 are MSB-first; bit 8 is the 9th (X/NA) bit.
- Driving: sio_d changes only on detected scl fall.
- States:
  - IDLE: wait for start.
  - DEVID: after 8 bits, compare [7:1] with DEVICE_ID.
    - Mismatch → IGNORE.
    - Match, R/W=0 → ADDR.
    - Match, R/W=1 → RDATA.
  - ADDR: after 8 bits, sub-address latched → WDATA.
  - WDATA: after 8 bits:
    - reg[addr]=byte.
    - reg_wr pulses 1 cycle with reg_addr/reg_wdata.
    - addr increments, wrapping 8'hFF→8'h00.
    - Stay in WDATA (sequential write).
  - RDATA:
    - On scl fall ending the 9th bit of DEVID, load reg[addr] and drive its MSB.
    - Drive bits 6..0 on the next falls.
    - Release on the fall after bit 0, so the initiator drives NA.
    - At the NA scl rise: NA=1 → IGNORE; NA=0 → addr+1, reload, continue.
    - addr increments after each read byte.
  - IGNORE: sio_d released; wait for stop/start.
- 9th bit: if DRIVE_ACK=1 and state ∈ {DEVID-match, ADDR, WDATA}, oe=1, sio_d=0 from the 8th-bit scl fall to the 9th-bit scl fall. Never driven in IDLE/IGNORE, or for a mismatched ID.
- Counter: 4 bits, 0..8, cleared after bit 8 and on start/stop.
- pwdn=1: same effect as stop every cycle; register contents kept; reg_wr=0.
- Simultaneous events:
  - scl and sda change in the same sampled cycle: treated as a data change (no start/stop).
  - Start and write-complete never coincide; write completes on the bit-8 rise, before any stop.
- A stop before a byte completes discards the partial byte.

Decomposition:
- Shared package sccb_pkg: state encodings (IDLE/DEVID/ADDR/WDATA/RDATA/IGNORE), SCCB_BITS_PER_PHASE=9, default DEVICE_ID. Package reused by the initiator.
- One sub-module, sccb_line_sync: 2-FF sync plus edge/start/stop detection for scl/sda, outputs scl_rise, scl_fall, start, stop.

Test Plan:
- 3-phase write: ID 0x42, sub 0x12, data 0x80 → reg_wr once, reg_addr=0x12, reg_wdata=0x80; reg[0x12]=0x80.
- Write then 2-phase read:
  - Write phases: ID 0x42, sub 0x12, stop.
  - Read phases: start, ID 0x43.
  - Expected: sio_d serialises 0x80 MSB-first; released at the NA bit; NA=1 then stop → IDLE.
- Sequential write: ID 0x42, sub 0xFF, data 0x11, 0x22 → reg[0xFF]=0x11, reg[0x00]=0x22; two reg_wr strobes.
- Wrong ID: ID 0x60, sub 0x05, data 0xAA → no reg_wr; sio_d never driven; state IGNORE until stop.
- Reset mid-write: sccb_reset_n=0 during data bit 4 → no reg_wr; oe=0; all outputs at reset values; next full transaction succeeds.
- Repeated start and pwdn:
  - Start inside ADDR → DEVID, counter=0.
  - pwdn=1 during RDATA → sio_d=z next cycle, state IDLE.
